rca_share_ctrl: RTL

RCA_SHARE_CTRL -- requirements
Module: rca_share_ctrl

---
 rtl/rca_share_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/rca_share_ctrl.sv
// Two-requester controller that time-shares one external 4-bit ripple adder,
// producing a W-bit add one nibble per cycle with a round-robin grant.
module rca_share_ctrl #(
  parameter int unsigned NIB = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               REQ0_VALID,
  input  logic               REQ1_VALID,
  output logic               REQ0_READY,
  output logic               REQ1_READY,
  input  logic [4*NIB-1:0]   REQ0_A,
  input  logic [4*NIB-1:0]   REQ0_B,
  input  logic [4*NIB-1:0]   REQ1_A,
  input  logic [4*NIB-1:0]   REQ1_B,
  input  logic               REQ0_CIN,
  input  logic               REQ1_CIN,
  output logic               RSP_VALID,
  input  logic               RSP_READY,
  output logic               RSP_ID,
  output logic [4*NIB-1:0]   RSP_SUM,
  output logic               RSP_COUT,
  output logic [3:0]         ADD_A,
  output logic [3:0]         ADD_B,
  output logic               ADD_CIN,
  input  logic [3:0]         ADD_SUM,
  input  logic               ADD_CARRY
);

  localparam int unsigned W  = 4 * NIB;
  localparam int unsigned KW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          r_state;
  logic [KW-1:0]   r_k;
  logic            r_last_gnt;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_cin;
  logic            r_carry;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_rsp_id;

  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_idle;
  logic            w_run;
  logic [3:0]      w_nib_a;
  logic [3:0]      w_nib_b;

  // Round-robin: on contention the requester that did not win last time goes first.
  always_comb begin
    w_gnt0 = REQ0_VALID && (!REQ1_VALID || r_last_gnt);
    w_gnt1 = REQ1_VALID && (!REQ0_VALID || !r_last_gnt);
  end

  // RST_N gates READY so nothing is offered while reset is held, regardless of inputs.
  assign w_idle     = RST_N && (r_state == StIdle);
  assign w_run      = (r_state == StRun);
  assign REQ0_READY = w_idle && w_gnt0;
  assign REQ1_READY = w_idle && w_gnt1;

  always_comb begin
    w_nib_a = 4'h0;
    w_nib_b = 4'h0;
    for (int i = 0; i < NIB; i++) begin
      if (r_k == KW'(i)) begin
        w_nib_a = r_a[4*i +: 4];
        w_nib_b = r_b[4*i +: 4];
      end
    end
  end

  assign ADD_A   = w_run ? w_nib_a : 4'h0;
  assign ADD_B   = w_run ? w_nib_b : 4'h0;
  assign ADD_CIN = w_run && ((r_k == '0) ? r_cin : r_carry);

  assign RSP_VALID = (r_state == StDone);
  assign RSP_ID    = r_rsp_id;
  assign RSP_SUM   = r_sum;
  assign RSP_COUT  = r_cout;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= StIdle;
      r_k        <= '0;
      r_last_gnt <= 1'b1;
      r_a        <= '0;
      r_b        <= '0;
      r_cin      <= 1'b0;
      r_carry    <= 1'b0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_rsp_id   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_gnt0 || w_gnt1) begin
            r_a        <= w_gnt1 ? REQ1_A : REQ0_A;
            r_b        <= w_gnt1 ? REQ1_B : REQ0_B;
            r_cin      <= w_gnt1 ? REQ1_CIN : REQ0_CIN;
            r_rsp_id   <= w_gnt1;
            r_last_gnt <= w_gnt1;
            r_k        <= '0;
            r_state    <= StRun;
          end
        end
        StRun: begin
          for (int i = 0; i < NIB; i++) begin
            if (r_k == KW'(i)) r_sum[4*i +: 4] <= ADD_SUM;
          end
          r_carry <= ADD_CARRY;
          if (r_k == KW'(NIB - 1)) begin
            r_cout  <= ADD_CARRY;
            r_state <= StDone;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        StDone: begin
          if (RSP_READY) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
